// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_unit_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: instruction memory port, redirect input and decode handshake.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;
  logic            fetch_enable;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    input  fetch_enable, imem_instr, redirect_valid, redirect_pc, out_ready,
    output imem_addr, out_valid, out_instr, out_pc
  );
  modport slave (
    output fetch_enable, imem_instr, redirect_valid, redirect_pc, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// DEPTH-entry synchronous FIFO of fetched {pc, instr} pairs with flush.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= AW'(wr_ptr + 1'b1);
      end
      if (pop) rd_ptr <= AW'(rd_ptr + 1'b1);
      count <= CW'(count + CW'(push) - CW'(pop));
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// PC register, push/pop arbitration and redirect handling in front of the fetch queue.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst_n,
  instruction_fetch_unit_if.master bus
);
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   count;
  logic            push, pop, full;
  fetch_entry_t    head, din;

  assign full = (count == CW'(DEPTH));
  // A redirect flushes the queue, so any handshake that cycle is moot.
  assign pop  = bus.out_valid && bus.out_ready && !bus.redirect_valid;
  assign push = bus.fetch_enable && !bus.redirect_valid && (!full || pop);
  assign din  = '{pc: pc, instr: bus.imem_instr};

  assign bus.imem_addr = pc;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  pc <= RESET_PC;
    else if (bus.redirect_valid) pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
    else if (push)               pc <= pc + XLEN'(INSTR_BYTES);
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );
endmodule
